// File: rtl/rx_arb_pkg.sv
// Shared types for the rx FIFO round-robin arbiter: FSM state encoding and
// an elaboration-time log2 helper used to sanity-check the channel tag width.
package rx_arb_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate the request vector so the search
// starts just after the last grant, take the lowest set bit, rotate back.
module rr_priority_pick #(
  parameter int NCH     = 4,
  parameter int CH_BITS = 2
) (
  input  logic [NCH-1:0]     i_req,
  input  logic [CH_BITS-1:0] i_last_grant,
  output logic [CH_BITS-1:0] o_grant,
  output logic               o_any
);

  logic [NCH-1:0] w_rot;
  int             w_start;
  int             w_idx;

  always_comb begin
    w_start = (int'(i_last_grant) + 1) % NCH;
    w_rot   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_rot[i] = i_req[(i + w_start) % NCH];
    end
    w_idx = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = i;
    end
    o_any   = |i_req;
    o_grant = CH_BITS'((w_idx + w_start) % NCH);
  end

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin readout of NCH per-channel rx FIFOs onto one valid/ready port,
// with bounded bursts per grant. Optional RX_ARB_STATS_EN adds word_count.
module rx_fifo_arbiter
  import rx_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CH_BITS   = 2,
  parameter int DATA_SIZE = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           ch_enable,
  input  logic [NCH-1:0]           fifo_empty,
  output logic [NCH-1:0]           fifo_read,
  input  logic [NCH*DATA_SIZE-1:0] fifo_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_SIZE-1:0]     out_data,
  output logic [CH_BITS-1:0]       out_ch,
  output logic                     busy,
  output state_t                   dbg_state
`ifdef RX_ARB_STATS_EN
  ,
  output logic [31:0]              word_count
`endif
);

  if (clog2(NCH) > CH_BITS) begin : g_bad_ch_bits
    $error("CH_BITS too narrow to tag NCH channels");
  end

  // Output port: a word is transferred in any cycle where out_valid && out_ready;
  // out_valid never drops and out_data/out_ch never change until that happens.
  state_t               r_state;
  logic [NCH-1:0]       r_fifo_read;
  logic                 r_out_valid;
  logic [DATA_SIZE-1:0] r_out_data;
  logic [CH_BITS-1:0]   r_out_ch;
  logic                 r_busy;
  logic [CH_BITS-1:0]   r_grant;
  logic [CH_BITS-1:0]   r_last_grant;
  logic [7:0]           r_burst_cnt;

  logic [NCH-1:0]       w_req;
  logic [CH_BITS-1:0]   w_pick;
  logic                 w_any;
  logic [8:0]           w_burst_next;
  logic                 w_handshake;
  logic [DATA_SIZE-1:0] w_words [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_words
    assign w_words[g] = fifo_data[g*DATA_SIZE +: DATA_SIZE];
  end

  assign w_req        = ch_enable & ~fifo_empty;
  assign w_burst_next = {1'b0, r_burst_cnt} + 9'd1;
  assign w_handshake  = (r_state == OUTPUT) && out_ready;

  rr_priority_pick #(
    .NCH     (NCH),
    .CH_BITS (CH_BITS)
  ) u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_any        (w_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_fifo_read  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_busy       <= 1'b0;
      r_grant      <= '0;
      r_last_grant <= CH_BITS'(NCH - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_fifo_read <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
            r_fifo_read <= NCH'(1) << w_pick;
            r_busy      <= 1'b1;
            r_state     <= READ;
          end
        end
        READ: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_out_data  <= w_words[r_grant];
          r_out_ch    <= r_grant;
          r_out_valid <= 1'b1;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_burst_cnt <= w_burst_next[7:0];
            // Empty flag has settled by now, so req reflects the FIFO after the last read.
            if ((w_burst_next < 9'(MAX_BURST)) && w_req[r_grant]) begin
              r_fifo_read <= NCH'(1) << r_grant;
              r_state     <= READ;
            end else begin
              r_last_grant <= r_grant;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RX_ARB_STATS_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_count <= '0;
    end else if (w_handshake && (r_word_count != 32'hFFFF_FFFF)) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`else
  logic w_unused_handshake;
  assign w_unused_handshake = w_handshake;
`endif

  assign fifo_read = r_fifo_read;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Bench for rx_fifo_arbiter: queue-based FIFO model, transaction-level
// round-robin predictor and an expected-word scoreboard.
module tb_rx_fifo_arbiter;

  localparam int NCH = 4;
  localparam int CHB = 2;
  localparam int DW  = 32;
  localparam int MB  = 8;

  logic              clk;
  logic              reset_n;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH-1:0]    fifo_read;
  logic [NCH*DW-1:0] fifo_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CHB-1:0]    out_ch;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef RX_ARB_STATS_EN
  logic [31:0]       word_count;
`endif

  rx_fifo_arbiter #(
    .NCH       (NCH),
    .CH_BITS   (CHB),
    .DATA_SIZE (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_enable  (ch_enable),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .busy       (busy),
    .dbg_state  (dbg_state)
`ifdef RX_ARB_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [DW-1:0]     fq [NCH][$];
  logic [CHB+DW-1:0] exp_q [$];
  int                hs_cyc [$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                hs_total = 0;
  int                m_last   = NCH - 1;
  int                ready_mode = 0;
  logic [NCH-1:0]    s_read;
  logic              s_valid;
  logic              s_busy;
  logic [CHB-1:0]    s_ch;
  logic [DW-1:0]     s_data;
  logic              p_stall = 1'b0;
  logic [CHB-1:0]    p_ch;
  logic [DW-1:0]     p_data;

  // ---------------- driver tasks ----------------
  task automatic refresh_empty();
    for (int i = 0; i < NCH; i++) fifo_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic fill(input int ch, input int n);
    for (int j = 0; j < n; j++) fq[ch].push_back($urandom);
  endtask

  // One clock: sample/check at negedge, apply FIFO pops and out_ready after posedge.
  task automatic step();
    logic [NCH-1:0]    rd;
    logic [CHB+DW-1:0] e;
    @(negedge clk);
    cyc++;
    s_read  = fifo_read;
    s_valid = out_valid;
    s_busy  = busy;
    s_ch    = out_ch;
    s_data  = out_data;
    rd      = fifo_read;
    n_checks++;
    if (!$onehot0(fifo_read) || ((fifo_read & (fifo_empty | ~ch_enable)) != '0)) begin
      n_fail++;
      $display("FAIL read_strobe cyc=%0d fifo_read=%b empty=%b enable=%b", cyc, fifo_read, fifo_empty, ch_enable);
    end
    if (p_stall) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== p_ch || out_data !== p_data || fifo_read !== '0) begin
        n_fail++;
        $display("FAIL hold cyc=%0d valid=%b ch=%0d data=%h read=%b required ch=%0d data=%h read=0",
                 cyc, out_valid, out_ch, out_data, fifo_read, p_ch, p_data);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_total++;
      hs_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word cyc=%0d ch=%0d data=%h required none", cyc, out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          n_fail++;
          $display("FAIL word cyc=%0d ch=%0d data=%h required ch=%0d data=%h",
                   cyc, out_ch, out_data, e[CHB+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    p_stall = (out_valid === 1'b1 && out_ready !== 1'b1);
    p_ch    = out_ch;
    p_data  = out_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rd[i] && fq[i].size() > 0) fifo_data[i*DW +: DW] = fq[i].pop_front();
    end
    refresh_empty();
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: with contents preloaded and enables static, each grant goes to the
  // next non-empty enabled channel after the previous one and takes min(MB, depth).
  task automatic predict(input logic [NCH-1:0] en);
    int cnt [NCH];
    int found;
    int n;
    int base;
    for (int i = 0; i < NCH; i++) cnt[i] = fq[i].size();
    forever begin
      found = -1;
      for (int k = 1; k <= NCH; k++) begin
        if (found < 0 && en[(m_last + k) % NCH] && cnt[(m_last + k) % NCH] > 0) found = (m_last + k) % NCH;
      end
      if (found < 0) break;
      n    = (cnt[found] < MB) ? cnt[found] : MB;
      base = fq[found].size() - cnt[found];
      for (int j = 0; j < n; j++) exp_q.push_back({CHB'(found), fq[found][base + j]});
      cnt[found] -= n;
      m_last = found;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout words_left=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) step();
    n_checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle busy=%b valid=%b required busy=0 valid=0", name, s_busy, s_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] w0;
    reset_n    = 1'b0;
    ch_enable  = '1;
    out_ready  = 1'b1;
    ready_mode = 0;
    fifo_data  = '0;
    for (int i = 0; i < NCH; i++) fill(i, 2);
    refresh_empty();
    w0 = fq[0][0];
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (fifo_read !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
        n_fail++;
        $display("FAIL reset_values read=%b valid=%b busy=%b data=%h ch=%0d required all 0",
                 fifo_read, out_valid, busy, out_data, out_ch);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_last  = NCH - 1;
    p_stall = 1'b0;
    hs_total = 0;
    cyc = 0;
    predict(ch_enable);
    step();
    n_checks++;
    if (s_read !== 4'b0000 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cycle1 read=%b busy=%b required 0000 0", s_read, s_busy);
    end
    step();
    n_checks++;
    if (s_read !== 4'b0001 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cycle2 read=%b busy=%b required 0001 1", s_read, s_busy);
    end
    step();
    n_checks++;
    if (s_read !== 4'b0000 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cycle3 read=%b valid=%b required 0000 0", s_read, s_valid);
    end
    step();
    n_checks++;
    if (s_valid !== 1'b1 || s_ch !== 2'd0 || s_data !== w0) begin
      n_fail++;
      $display("FAIL cycle4 valid=%b ch=%0d data=%h required 1 0 %h", s_valid, s_ch, s_data, w0);
    end
    drain("reset", 400);
  endtask

  task automatic test_single_channel();
    ch_enable  = '1;
    ready_mode = 0;
    fq[2].push_back(32'hA0);
    fq[2].push_back(32'hA1);
    fq[2].push_back(32'hA2);
    refresh_empty();
    predict(ch_enable);
    hs_cyc.delete();
    drain("single", 100);
    n_checks++;
    if (hs_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL single_count words=%0d required 3", hs_cyc.size());
    end else begin
      n_checks++;
      if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
        n_fail++;
        $display("FAIL single_spacing gaps=%0d,%0d required 3,3", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
      end
    end
  endtask

  task automatic test_fairness();
    ch_enable  = '1;
    ready_mode = 0;
    for (int i = 0; i < NCH; i++) fill(i, 20);
    refresh_empty();
    predict(ch_enable);
    drain("fairness", 1200);
  endtask

  task automatic test_backpressure();
    int k = 0;
    ch_enable  = '1;
    ready_mode = 2;
    out_ready  = 1'b0;
    fill(1, 3);
    refresh_empty();
    predict(ch_enable);
    s_valid = 1'b0;
    while (s_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid valid=%b required 1", s_valid);
    end
    repeat (10) step();
    n_checks++;
    if (s_valid !== 1'b1 || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL bp_stalled valid=%b pending=%0d required 1 3", s_valid, exp_q.size());
    end
    ready_mode = 0;
    out_ready  = 1'b1;
    drain("backpressure", 100);
  endtask

  task automatic test_enable_mask();
    ch_enable  = 4'b1010;
    ready_mode = 1;
    for (int i = 0; i < NCH; i++) fill(i, 5);
    refresh_empty();
    predict(ch_enable);
    drain("enable_mask", 400);
    n_checks++;
    if (fq[0].size() != 5 || fq[2].size() != 5) begin
      n_fail++;
      $display("FAIL mask_untouched ch0=%0d ch2=%0d required 5 5", fq[0].size(), fq[2].size());
    end
    fq[0].delete();
    fq[2].delete();
    refresh_empty();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      ch_enable  = NCH'($urandom_range(1, (1 << NCH) - 1));
      ready_mode = 1;
      for (int i = 0; i < NCH; i++) fill(i, $urandom_range(0, 12));
      refresh_empty();
      predict(ch_enable);
      drain("random", 1500);
    end
    for (int i = 0; i < NCH; i++) fq[i].delete();
    refresh_empty();
  endtask

  task automatic test_stats();
`ifdef RX_ARB_STATS_EN
    n_checks++;
    if (word_count !== 32'(hs_total)) begin
      n_fail++;
      $display("FAIL stats_count word_count=%0d required %0d", word_count, hs_total);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (word_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset word_count=%0d required 0", word_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n    = 1'b0;
    ch_enable  = '1;
    fifo_empty = '1;
    fifo_data  = '0;
    out_ready  = 1'b1;
    test_reset();
    test_single_channel();
    test_fairness();
    test_backpressure();
    test_enable_mask();
    test_random();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
